// File: rtl/gru_uart_pkg.sv
// Shared definitions for the prediction UART transmitter.
// Frame FSM state enum, frame length constants and default HEADER/BAUD/clock.
// Build option: PRED_TX_CHECKSUM_EN appends an XOR checksum byte (6-byte frame).
package gru_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StNext,
    StDone
  } frame_state_e;

  localparam int unsigned FrameLenBase  = 5;
  localparam int unsigned FrameLenCksum = 6;

`ifdef PRED_TX_CHECKSUM_EN
  localparam int unsigned FrameLen = FrameLenCksum;
`else
  localparam int unsigned FrameLen = FrameLenBase;
`endif

  // Wide enough for a byte index of 0..FrameLen-1.
  localparam int unsigned ByteIdxW = 3;

  localparam int unsigned DefaultClkFreq = 50_000_000;
  localparam int unsigned DefaultBaud    = 115200;
  localparam logic [7:0]  DefaultHeader  = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser with a bit timer.
// Ports:
//   clk_i    - system clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   start_i  - accept byte_i when ready_o is high
//   byte_i   - byte to send, LSB first
//   txd_o    - serial line, idles high
//   ready_o  - idle, or in the final cycle of the stop bit (allows back-to-back bytes)
module uart_tx_byte #(
  parameter int unsigned ClksPerBit = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       txd_o,
  output logic       ready_o
);

  localparam int unsigned CntW    = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);
  localparam logic [3:0] StopIdx = 4'd9;

  logic            active_q, active_d;
  logic            txd_q, txd_d;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntMax);
  // Ready one cycle early so the next start bit follows the stop bit with no gap.
  assign ready_o = ~active_q | (bit_end & (bit_q == StopIdx));
  assign txd_o   = txd_q;

  always_comb begin
    active_d = active_q;
    txd_d    = txd_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (start_i && ready_o) begin
      active_d = 1'b1;
      txd_d    = 1'b0;
      shift_d  = {1'b1, byte_i};  // stop bit rides above the data bits
      bit_d    = '0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == StopIdx) begin
          active_d = 1'b0;
          txd_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[8:1]};
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      txd_q    <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      txd_q    <= txd_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pred_uart_tx.sv
// Sends a 32-bit prediction word over UART as a framed burst:
//   HEADER, pred_data[31:24], [23:16], [15:8], [7:0] (8N1, no inter-byte gap).
// Build option: PRED_TX_CHECKSUM_EN appends XOR of the preceding five bytes.
// Ports:
//   CLOCK_50   - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   pred_valid - level; its rising edge triggers a frame when idle
//   pred_data  - word captured on the trigger
//   uart_txd   - serial line, idles high
//   busy       - frame in progress
//   tx_done    - one-cycle pulse after the final stop bit
module pred_uart_tx
  import gru_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DefaultClkFreq,
  parameter int unsigned BAUD     = DefaultBaud,
  parameter logic [7:0]  HEADER   = DefaultHeader
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        pred_valid,
  input  logic [31:0] pred_data,
  output logic        uart_txd,
  output logic        busy,
  output logic        tx_done
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam logic [ByteIdxW-1:0] LastIdx = ByteIdxW'(FrameLen - 1);

  frame_state_e        state_q, state_d;
  logic [ByteIdxW-1:0] idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                valid_q;
  logic                trig;
  logic                tx_start;
  logic                tx_ready;
  logic [7:0]          tx_byte;

  assign trig    = pred_valid & ~valid_q;
  assign busy    = busy_q;
  assign tx_done = (state_q == StDone);

`ifdef PRED_TX_CHECKSUM_EN
  logic [7:0] cksum;
  assign cksum = HEADER ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
`endif

  always_comb begin
    tx_byte = HEADER;
    case (idx_q)
      3'd1:    tx_byte = data_q[31:24];
      3'd2:    tx_byte = data_q[23:16];
      3'd3:    tx_byte = data_q[15:8];
      3'd4:    tx_byte = data_q[7:0];
`ifdef PRED_TX_CHECKSUM_EN
      3'd5:    tx_byte = cksum;
`endif
      default: tx_byte = HEADER;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    busy_d   = busy_q;
    tx_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          data_d  = pred_data;
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        busy_d   = 1'b1;
        tx_start = tx_ready;
        if (tx_ready) state_d = StSend;
      end
      StSend: state_d = StNext;
      StNext: begin
        if (idx_q != LastIdx) begin
          idx_d   = idx_q + 3'd1;
          state_d = StLoad;
        end else if (tx_ready) begin
          // Last byte is in its final stop-bit cycle.
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= pred_valid;
    end
  end

  uart_tx_byte #(
    .ClksPerBit(ClksPerBit)
  ) u_tx_byte (
    .clk_i  (CLOCK_50),
    .rst_ni (rst_n),
    .start_i(tx_start),
    .byte_i (tx_byte),
    .txd_o  (uart_txd),
    .ready_o(tx_ready)
  );

endmodule

// File: tb/tb_pred_uart_tx.sv
// Directed bench for pred_uart_tx: a small-divider instance (1000 Hz / 100 baud)
// for frame content and timing, and a default-parameter instance for bit period.
module tb_pred_uart_tx;

  localparam int Cpb = 10;  // 1000 / 100
`ifdef PRED_TX_CHECKSUM_EN
  localparam int N = 6;
`else
  localparam int N = 5;
`endif
  localparam int FT = N * 10 * Cpb;  // line time of one frame in cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv, pv2;
  logic [31:0] pd, pd2;
  logic        txd, bsy, dn;
  logic        txd2, bsy2, dn2;

  int n_total = 0;
  int n_pass  = 0;

  logic ln [0:2199];
  logic bz [0:2199];
  logic dq [0:2199];

  logic [7:0] exp_b [0:5] = '{8'hA5, 8'h3F, 8'h80, 8'h00, 8'h00, 8'h1A};

  always #5 clk = ~clk;

  pred_uart_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100),
    .HEADER  (8'hA5)
  ) u_dut (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .pred_valid(pv),
    .pred_data (pd),
    .uart_txd  (txd),
    .busy      (bsy),
    .tx_done   (dn)
  );

  pred_uart_tx u_dut_def (
    .CLOCK_50  (clk),
    .rst_n     (rst_n),
    .pred_valid(pv2),
    .pred_data (pd2),
    .uart_txd  (txd2),
    .busy      (bsy2),
    .tx_done   (dn2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sample cycles 0..ncyc (cycle 0 follows the first edge); optional pred_valid actions.
  task automatic record(input int ncyc, input int lo_cyc, input int hi_cyc,
                        input logic [31:0] hi_data);
    for (int c = 0; c <= ncyc; c++) begin
      tick();
      ln[c] = txd;
      bz[c] = bsy;
      dq[c] = dn;
      if (c == lo_cyc) pv = 1'b0;
      if (c == hi_cyc) begin
        pd = hi_data;
        pv = 1'b1;
      end
    end
  endtask

  // Mid-bit samples of byte b of a frame captured at cycle base: {stop, data, start}.
  function automatic logic [9:0] frame_bits(input int base, input int b);
    logic [9:0] v;
    for (int k = 0; k < 10; k++) v[k] = ln[base + 1 + (b * 10 + k) * Cpb + Cpb / 2];
    return v;
  endfunction

  function automatic int cnt_busy(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (bz[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (dq[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_done(input int a, input int b);
    for (int i = a; i <= b; i++) if (dq[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic all_high(input int a, input int b);
    for (int i = a; i <= b; i++) if (ln[i] !== 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int fall, rise, fall2;
    rst_n = 1'b0;
    pv = 1'b0; pd = '0;
    pv2 = 1'b0; pd2 = '0;
    repeat (3) tick();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_done", 32'(dn), 32'd0);
    chk("rst_txd_def", 32'(txd2), 32'd1);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_txd", 32'(txd), 32'd1);

    // Basic frame
    pd = 32'h3F80_0000; pv = 1'b1;
    record(FT + 100, 3, -1, '0);
    chk("busy_c0", 32'(bz[0]), 32'd0);
    chk("busy_c1", 32'(bz[1]), 32'd1);
    chk("line_c0", 32'(ln[0]), 32'd1);
    chk("start_c1", 32'(ln[1]), 32'd0);
    for (int b = 0; b < N; b++)
      chk($sformatf("byte%0d", b), 32'(frame_bits(0, b)), 32'({1'b1, exp_b[b], 1'b0}));
    chk("done_cycle", 32'(first_done(0, FT + 100)), 32'(FT + 1));
    chk("busy_len", 32'(cnt_busy(0, FT + 100)), 32'(FT));
    chk("done_pulses", 32'(cnt_done(0, FT + 100)), 32'd1);
    chk("idle_after", 32'(all_high(FT + 1, FT + 100)), 32'd1);

    // Trigger in the tx_done cycle is ignored
    pd = 32'h3F80_0000; pv = 1'b1;
    record(FT + 400, 3, FT + 1, 32'h1111_1111);
    pv = 1'b0;
    tick();
    chk("donecyc_pulses", 32'(cnt_done(0, FT + 400)), 32'd1);
    chk("donecyc_busy", 32'(cnt_busy(0, FT + 400)), 32'(FT));

    // Trigger one cycle later is accepted
    pd = 32'h3F80_0000; pv = 1'b1;
    record(2 * FT + 200, 3, FT + 2, 32'h1234_5678);
    pv = 1'b0;
    tick();
    chk("late_busy_c0", 32'(bz[FT + 3]), 32'd0);
    chk("late_busy_c1", 32'(bz[FT + 4]), 32'd1);
    chk("late_start", 32'(ln[FT + 4]), 32'd0);
    chk("late_byte1", 32'(frame_bits(FT + 3, 1)), 32'({1'b1, 8'h12, 1'b0}));
    chk("late_done", 32'(first_done(FT + 3, 2 * FT + 200)), 32'(2 * FT + 4));

    // Rising edge mid-frame is ignored
    pd = 32'h3F80_0000; pv = 1'b1;
    record(2 * FT + 200, 3, 200, 32'hDEAD_BEEF);
    pv = 1'b0;
    tick();
    for (int b = 1; b < 5; b++)
      chk($sformatf("mid_byte%0d", b), 32'(frame_bits(0, b)), 32'({1'b1, exp_b[b], 1'b0}));
    chk("mid_pulses", 32'(cnt_done(0, 2 * FT + 200)), 32'd1);
    chk("mid_busy", 32'(cnt_busy(0, 2 * FT + 200)), 32'(FT));

    // Held-high level gives one frame
    pd = 32'h3F80_0000; pv = 1'b1;
    record(2100, 2000, -1, '0);
    tick();
    chk("held_pulses", 32'(cnt_done(0, 2100)), 32'd1);
    chk("held_busy", 32'(cnt_busy(0, 2100)), 32'(FT));
    chk("held_done", 32'(first_done(0, 2100)), 32'(FT + 1));

    // Reset mid-frame
    pd = 32'h3F80_0000; pv = 1'b1;
    record(250, 3, -1, '0);
    rst_n = 1'b0;
    #1;
    chk("mrst_txd", 32'(txd), 32'd1);
    chk("mrst_busy", 32'(bsy), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    record(1000, -1, -1, '0);
    chk("mrst_idle", 32'(all_high(0, 1000)), 32'd1);
    chk("mrst_nobusy", 32'(cnt_busy(0, 1000)), 32'd0);
    chk("mrst_nodone", 32'(cnt_done(0, 1000)), 32'd0);

    // pred_valid already high at reset release
    rst_n = 1'b0; pv = 1'b1; pd = 32'h3F80_0000;
    repeat (2) tick();
    rst_n = 1'b1;
    record(FT + 50, 3, -1, '0);
    chk("rel_busy_c1", 32'(bz[1]), 32'd1);
    chk("rel_start", 32'(ln[1]), 32'd0);
    chk("rel_byte0", 32'(frame_bits(0, 0)), 32'({1'b1, 8'hA5, 1'b0}));
    chk("rel_done", 32'(first_done(0, FT + 50)), 32'(FT + 1));

    // Default parameters: 434-cycle bit period (A5: start 0, d0 1, d1 0)
    pd2 = 32'h3F80_0000; pv2 = 1'b1;
    fall = -1; rise = -1; fall2 = -1;
    for (int c = 0; c <= 1500; c++) begin
      tick();
      if (fall < 0 && txd2 === 1'b0) fall = c;
      else if (fall >= 0 && rise < 0 && txd2 === 1'b1) rise = c;
      else if (rise >= 0 && fall2 < 0 && txd2 === 1'b0) fall2 = c;
    end
    chk("def_start_cyc", 32'(fall), 32'd1);
    chk("def_start_len", 32'(rise - fall), 32'd434);
    chk("def_d0_len", 32'(fall2 - rise), 32'd434);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
